// File: rtl/minmax_pkg.sv
// Shared encodings for the min/max block scanner: FSM states and comparator result bit positions.
package minmax_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FIRST   = 3'd1,
    S_WAIT    = 3'd2,
    S_CMP_MAX = 3'd3,
    S_CMP_MIN = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam int CMP_LT = 2;
  localparam int CMP_EQ = 1;
  localparam int CMP_GT = 0;

endpackage

// File: rtl/cmp_mag_en.sv
// DW-bit unsigned magnitude comparator, MSB-first cascade of enable-chained 1-bit cells.
// Purely combinational; e=0 forces {lt,eq,gt}=0.
module cmp_mag_en
  import minmax_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          e,
  output logic [2:0]    res
);

  // en_c[i+1] is high while all bits above i are equal; it enables cell i.
  logic [DW:0]   en_c;
  logic [DW-1:0] gt_b;
  logic [DW-1:0] lt_b;

  assign en_c[DW] = e;

  for (genvar i = DW - 1; i >= 0; i--) begin : g_cell
    assign gt_b[i] = en_c[i+1] &  a[i] & ~b[i];
    assign lt_b[i] = en_c[i+1] & ~a[i] &  b[i];
    assign en_c[i] = en_c[i+1] & ~(a[i] ^ b[i]);
  end

  always_comb begin
    res         = '0;
    res[CMP_LT] = |lt_b;
    res[CMP_EQ] = en_c[0];
    res[CMP_GT] = |gt_b;
  end

endmodule

// File: rtl/minmax_scan_ctrl.sv
// Block max/min finder sharing one comparator; first sample 1 cycle, later samples 3 cycles each.
// din_ready is a Moore decode of state (high in FIRST/WAIT only); source stalls simply hold state.
module minmax_scan_ctrl
  import minmax_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  parameter int DW        = 8,
  localparam int CW       = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [DW-1:0] max_out,
  output logic [DW-1:0] min_out,
  output logic [CW-1:0] max_idx,
  output logic [CW-1:0] min_idx,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] LAST_IDX = CW'(N_SAMPLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] s_q, s_d;
  logic [DW-1:0] max_q, max_d;
  logic [DW-1:0] min_q, min_d;
  logic [CW-1:0] maxi_q, maxi_d;
  logic [CW-1:0] mini_q, mini_d;

  logic          cmp_en;
  logic [DW-1:0] cmp_b;
  logic [2:0]    cmp_res;

  cmp_mag_en #(.DW(DW)) u_cmp (
    .a   (s_q),
    .b   (cmp_b),
    .e   (cmp_en),
    .res (cmp_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      max_q   <= '0;
      min_q   <= '0;
      maxi_q  <= '0;
      mini_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      max_q   <= max_d;
      min_q   <= min_d;
      maxi_q  <= maxi_d;
      mini_q  <= mini_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    max_d   = max_q;
    min_d   = min_q;
    maxi_d  = maxi_q;
    mini_d  = mini_q;
    cmp_en  = 1'b0;
    cmp_b   = max_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FIRST;
          cnt_d   = '0;
        end
      end
      S_FIRST: begin
        if (din_valid && din_ready) begin
          max_d   = din;
          min_d   = din;
          maxi_d  = '0;
          mini_d  = '0;
          cnt_d   = CW'(1);
          state_d = (N_SAMPLES == 1) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (din_valid && din_ready) begin
          s_d     = din;
          state_d = S_CMP_MAX;
        end
      end
      S_CMP_MAX: begin
        cmp_en = 1'b1;
        cmp_b  = max_q;
        // Strict compare: a tie keeps the earlier index.
        if (cmp_res[CMP_GT] && !cmp_res[CMP_EQ]) begin
          max_d  = s_q;
          maxi_d = cnt_q;
        end
        state_d = S_CMP_MIN;
      end
      S_CMP_MIN: begin
        cmp_en = 1'b1;
        cmp_b  = min_q;
        if (cmp_res[CMP_LT] && !cmp_res[CMP_EQ]) begin
          min_d  = s_q;
          mini_d = cnt_q;
        end
        if (cnt_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign din_ready = (state_q == S_FIRST) || (state_q == S_WAIT);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign max_out   = max_q;
  assign min_out   = min_q;
  assign max_idx   = maxi_q;
  assign min_idx   = mini_q;

endmodule

// File: tb/tb_minmax_scan_ctrl.sv
// Scoreboard bench for minmax_scan_ctrl: expected block results are queued at stimulus time and
// popped by monitors on each done pulse; an N_SAMPLES=1 instance covers the single-sample case.
module tb_minmax_scan_ctrl;

  typedef struct packed {
    logic [7:0] mx;
    logic [7:0] mn;
    logic [2:0] mxi;
    logic [2:0] mni;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] max_out, min_out;
  logic [2:0] max_idx, min_idx;
  logic       busy, done;

  logic       start1;
  logic [7:0] din1;
  logic       din1_valid;
  logic       din1_ready;
  logic [7:0] max1, min1;
  logic [0:0] maxi1, mini1;
  logic       busy1, done1;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int done1_cnt = 0;
  exp_t q[$];
  exp_t q1[$];
  logic [7:0] vec [8];

  minmax_scan_ctrl #(.N_SAMPLES(8), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .max_out(max_out), .min_out(min_out),
    .max_idx(max_idx), .min_idx(min_idx), .busy(busy), .done(done)
  );

  minmax_scan_ctrl #(.N_SAMPLES(1), .DW(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .din(din1), .din_valid(din1_valid),
    .din_ready(din1_ready), .max_out(max1), .min_out(min1),
    .max_idx(maxi1), .min_idx(mini1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for the 8-sample instance.
  int xfer = 0;
  int cmp_left = 0;
  bit busy_chk = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      xfer = 0;
      cmp_left = 0;
      busy_chk = 0;
    end else begin
      if (cmp_left > 0) begin
        chk("ready_low_in_cmp", {31'd0, din_ready}, 32'd0);
        cmp_left--;
      end
      if (busy_chk) begin
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        busy_chk = 0;
      end
      if (din_valid && din_ready) begin
        if (xfer > 0) cmp_left = 2;
        xfer++;
      end
      if (done) begin
        exp_t e;
        done_cnt++;
        chk("xfer_count", xfer, 32'd8);
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        xfer = 0;
        busy_chk = 1;
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("max_out", {24'd0, max_out}, {24'd0, e.mx});
          chk("min_out", {24'd0, min_out}, {24'd0, e.mn});
          chk("max_idx", {29'd0, max_idx}, {29'd0, e.mxi});
          chk("min_idx", {29'd0, min_idx}, {29'd0, e.mni});
        end
      end
    end
  end

  // Monitor for the single-sample instance.
  always @(negedge clk) begin
    if (rst_n && done1) begin
      exp_t e;
      done1_cnt++;
      if (q1.size() == 0) begin
        chk("n1_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("n1_max_out", {24'd0, max1}, {24'd0, e.mx});
        chk("n1_min_out", {24'd0, min1}, {24'd0, e.mn});
        chk("n1_max_idx", {31'd0, maxi1}, {31'd0, e.mxi[0]});
        chk("n1_min_idx", {31'd0, mini1}, {31'd0, e.mni[0]});
      end
    end
  end

  task automatic send_block(input logic [7:0] s [8], input exp_t e, input bit gaps,
                            input bit mid_start, input int n_send);
    int d0;
    int k;
    d0 = done_cnt;
    if (n_send == 8) q.push_back(e);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < n_send; i++) begin
      if (gaps) begin
        din_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      din = s[i];
      din_valid = 1'b1;
      if (mid_start && i == 3) start = 1'b1;
      k = 0;
      while (!din_ready && k < 50) begin
        @(posedge clk); #1;
        k++;
      end
      if (!din_ready) chk("ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
      if (gaps) din_valid = 1'b0;
    end
    din_valid = 1'b0;
    if (n_send == 8) begin
      k = 0;
      while (done_cnt == d0 && k < 20) begin
        @(posedge clk); #1;
        k++;
      end
      chk("done_seen", {31'd0, done_cnt != d0}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_max"}, {24'd0, max_out}, 32'd0);
    chk({tag, "_min"}, {24'd0, min_out}, 32'd0);
    chk({tag, "_idx"}, {26'd0, max_idx, min_idx}, 32'd0);
    chk({tag, "_ctl"}, {29'd0, din_ready, busy, done}, 32'd0);
  endtask

  initial begin
    exp_t e;
    int k;
    rst_n = 1'b0;
    start = 1'b0; din = '0; din_valid = 1'b0;
    start1 = 1'b0; din1 = '0; din1_valid = 1'b0;

    // Reset state, with the source already presenting a sample.
    repeat (2) @(negedge clk);
    din_valid = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_n1", {8'd0, max1, min1, 5'd0, maxi1, mini1, din1_ready, busy1, done1}, 32'd0);
    din_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_reset", {30'd0, busy, din_ready}, 32'd0);

    // Mixed values, valid held high.
    vec = '{8'h10, 8'h80, 8'h05, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'h01};
    e = '{mx: 8'hFF, mn: 8'h00, mxi: 3'd3, mni: 3'd4};
    send_block(vec, e, 1'b0, 1'b0, 8);

    // All equal: ties never update.
    vec = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    e = '{mx: 8'hAA, mn: 8'hAA, mxi: 3'd0, mni: 3'd0};
    send_block(vec, e, 1'b0, 1'b0, 8);

    // Same as first block with random source gaps.
    vec = '{8'h10, 8'h80, 8'h05, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'h01};
    e = '{mx: 8'hFF, mn: 8'h00, mxi: 3'd3, mni: 3'd4};
    send_block(vec, e, 1'b1, 1'b0, 8);

    // Start pulsed mid-block; duplicates of extremes keep first index.
    vec = '{8'h20, 8'h20, 8'h9C, 8'h01, 8'h9C, 8'h01, 8'h55, 8'h30};
    e = '{mx: 8'h9C, mn: 8'h01, mxi: 3'd2, mni: 3'd3};
    send_block(vec, e, 1'b0, 1'b1, 8);
    chk("prev_result_held", {16'd0, max_out, min_out}, 32'h9C01);

    // Abort after 4 samples with reset.
    vec = '{8'h44, 8'hEE, 8'h02, 8'h99, 8'h00, 8'h00, 8'h00, 8'h00};
    send_block(vec, e, 1'b0, 1'b0, 4);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Fresh block after the abort: ascending ramp.
    vec = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    e = '{mx: 8'h07, mn: 8'h00, mxi: 3'd7, mni: 3'd0};
    send_block(vec, e, 1'b0, 1'b0, 8);

    // Single-sample block: done in the cycle right after the transfer.
    q1.push_back('{mx: 8'h3C, mn: 8'h3C, mxi: 3'd0, mni: 3'd0});
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    din1 = 8'h3C;
    din1_valid = 1'b1;
    k = 0;
    while (!din1_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    din1_valid = 1'b0;
    chk("n1_done_latency", {31'd0, done1}, 32'd1);
    repeat (3) @(posedge clk);
    #1;

    chk("done_count", done_cnt, 32'd5);
    chk("n1_done_count", done1_cnt, 32'd1);
    chk("scoreboard_empty", q.size() + q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
